// File: rtl/fpu_round_pack.sv
// Round-and-pack stage of the single-precision FP multiplier: two-stage elastic pipeline.
// Optional flush-to-zero of subnormal results when FPU_ROUND_FTZ_EN is defined.
module fpu_round_pack #(
  parameter int unsigned TAG_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign,
  input  logic [23:0]          in_mantissa,
  input  logic [7:0]           in_exponent,
  input  logic [2:0]           in_guard,
  input  logic                 in_nan,
  input  logic                 in_inf,
  input  logic                 in_zero,
  input  logic [2:0]           in_mode,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_result,
  output logic [4:0]           out_flags,
  output logic [TAG_WIDTH-1:0] out_tag
);

  localparam int unsigned MANT_W = 24;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_NX = 0;

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  localparam logic [31:0]      QNAN       = 32'h7FC0_0000;
  localparam logic [EXP_W-1:0] EXP_ALL1   = 8'hFF;
  localparam logic [EXP_W-1:0] EXP_MAXFIN = 8'hFE;

  logic                 s1_valid;
  logic                 s1_adv;
  logic                 s1_sign;
  logic [MANT_W-1:0]    s1_mantissa;
  logic [EXP_W-1:0]     s1_exponent;
  logic                 s1_inexact;
  logic                 s1_inc;
  logic                 s1_nan;
  logic                 s1_inf;
  logic                 s1_zero;
  logic [2:0]           s1_mode;
  logic [TAG_WIDTH-1:0] s1_tag;

  logic [2:0]           mode_n;
  logic                 inexact;
  logic                 inc;

  logic [MANT_W:0]      sum;
  logic [EXP_W:0]       exp_r;
  logic [FRAC_W-1:0]    frac_r;
  logic                 overflow;
  logic                 to_inf;
  logic [31:0]          next_result;
  logic [4:0]           next_flags;

  // Stage 1 advances whenever the output register is empty or being drained.
  assign s1_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s1_adv;

  // Round-up decision from guard/round/sticky; unknown modes fall back to RNE.
  always_comb begin
    mode_n  = in_mode;
    inexact = |in_guard;
    inc     = 1'b0;
    if (in_mode > RM_RMM) mode_n = RM_RNE;
    case (mode_n)
      RM_RNE:  inc = in_guard[2] & (in_guard[1] | in_guard[0] | in_mantissa[0]);
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = in_sign & inexact;
      RM_RUP:  inc = !in_sign & inexact;
      RM_RMM:  inc = in_guard[2];
      default: inc = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
    end
  end

  // Stage 1 payload needs no reset; it is qualified by s1_valid.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_sign     <= in_sign;
      s1_mantissa <= in_mantissa;
      s1_exponent <= in_exponent;
      s1_inexact  <= inexact;
      s1_inc      <= inc;
      s1_nan      <= in_nan;
      s1_inf      <= in_inf;
      s1_zero     <= in_zero;
      s1_mode     <= mode_n;
      s1_tag      <= in_tag;
    end
  end

  // Stage 2: apply increment, renormalize on carry, detect overflow and pack.
  always_comb begin
    sum      = {1'b0, s1_mantissa} + (MANT_W+1)'(s1_inc);
    exp_r    = {1'b0, s1_exponent};
    frac_r   = sum[FRAC_W-1:0];
    if (sum[MANT_W]) begin
      exp_r  = exp_r + 9'd1;
      frac_r = '0;
    end else if ((s1_exponent == '0) && sum[FRAC_W]) begin
      exp_r  = 9'd1;
    end
    overflow = exp_r >= {1'b0, EXP_ALL1};

    case (s1_mode)
      RM_RTZ:  to_inf = 1'b0;
      RM_RDN:  to_inf = s1_sign;
      RM_RUP:  to_inf = !s1_sign;
      default: to_inf = 1'b1;
    endcase

    next_result = {s1_sign, exp_r[EXP_W-1:0], frac_r};
    next_flags  = '0;
    if (s1_nan) begin
      next_result = QNAN;
    end else if (s1_inf) begin
      next_result = {s1_sign, EXP_ALL1, {FRAC_W{1'b0}}};
    end else if (s1_zero) begin
      next_result = {s1_sign, 31'd0};
    end else if (overflow) begin
      next_result          = to_inf ? {s1_sign, EXP_ALL1, {FRAC_W{1'b0}}}
                                    : {s1_sign, EXP_MAXFIN, {FRAC_W{1'b1}}};
      next_flags[FLAG_OF]  = 1'b1;
      next_flags[FLAG_NX]  = 1'b1;
    end else begin
      next_flags[FLAG_NX]  = s1_inexact;
      next_flags[FLAG_UF]  = s1_inexact && (exp_r[EXP_W-1:0] == '0);
`ifdef FPU_ROUND_FTZ_EN
      if ((exp_r[EXP_W-1:0] == '0) && (frac_r != '0)) begin
        next_result         = {s1_sign, 31'd0};
        next_flags[FLAG_UF] = 1'b1;
        next_flags[FLAG_NX] = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
      out_tag    <= '0;
    end else if (s1_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= next_result;
        out_flags  <= next_flags;
        out_tag    <= s1_tag;
      end
    end
  end

endmodule

// File: tb/tb_fpu_round_pack.sv
// Bench for fpu_round_pack: directed cases plus randomized traffic against an arithmetic model.
// Define FPU_ROUND_FTZ_EN for both DUT and bench to check the flush-to-zero build.
module tb_fpu_round_pack;

  localparam int unsigned TW = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_sign;
  logic [23:0]   in_mantissa;
  logic [7:0]    in_exponent;
  logic [2:0]    in_guard;
  logic          in_nan;
  logic          in_inf;
  logic          in_zero;
  logic [2:0]    in_mode;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_result;
  logic [4:0]    out_flags;
  logic [TW-1:0] out_tag;

  typedef struct {
    logic [31:0]   res;
    logic [4:0]    flags;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  fpu_round_pack #(.TAG_WIDTH(TW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_mantissa(in_mantissa), .in_exponent(in_exponent),
    .in_guard(in_guard), .in_nan(in_nan), .in_inf(in_inf), .in_zero(in_zero),
    .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags), .out_tag(out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, want, $time);
    end
  endtask

  // Reference: treat the significand as an integer, round by comparing the
  // 3-bit remainder against one half, then renormalize by value.
  function automatic exp_t model(input logic s, input logic [23:0] mant, input logic [7:0] ex,
                                 input logic [2:0] g, input logic nan, input logic inf,
                                 input logic zero, input logic [2:0] mode, input logic [TW-1:0] tag);
    exp_t        r;
    int unsigned md;
    int unsigned rem;
    int unsigned mm;
    int          e;
    bit          up;
    bit          inexact;
    bit          to_inf;
    r.tag   = tag;
    r.flags = 5'b0;
    md      = (mode > 3'd4) ? 0 : int'(mode);
    if (nan) begin
      r.res = 32'h7FC0_0000;
    end else if (inf) begin
      r.res = {s, 8'hFF, 23'd0};
    end else if (zero) begin
      r.res = {s, 31'd0};
    end else begin
      rem     = int'(g);
      inexact = (rem != 0);
      case (md)
        0:       up = (rem > 4) || (rem == 4 && mant[0]);
        1:       up = 1'b0;
        2:       up = s && inexact;
        3:       up = !s && inexact;
        default: up = (rem >= 4);
      endcase
      mm = int'(mant) + (up ? 1 : 0);
      e  = int'(ex);
      if (mm >= (1 << 24)) begin
        mm = mm >> 1;
        e  = e + 1;
      end else if (e == 0 && mm >= (1 << 23)) begin
        e = 1;
      end
      if (e >= 255) begin
        to_inf  = (md == 0) || (md == 4) || (md == 2 && s) || (md == 3 && !s);
        r.res   = to_inf ? {s, 8'hFF, 23'd0} : {s, 8'hFE, 23'h7FFFFF};
        r.flags = 5'b00101;
      end else begin
        r.res      = {s, 8'(e), 23'(mm)};
        r.flags[0] = inexact;
        r.flags[1] = inexact && (e == 0);
`ifdef FPU_ROUND_FTZ_EN
        if (e == 0 && 23'(mm) != 23'd0) begin
          r.res   = {s, 31'd0};
          r.flags = 5'b00011;
        end
`endif
      end
    end
    return r;
  endfunction

  // Scoreboard: every cycle out_valid is high the output must equal the oldest pending result.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_out", 32'(out_valid), 32'd0);
        end else begin
          check("sb_result", out_result, sb_q[0].res);
          check("sb_flags", 32'(out_flags), 32'(sb_q[0].flags));
          check("sb_tag", 32'(out_tag), 32'(sb_q[0].tag));
          if (out_ready) void'(sb_q.pop_front());
        end
      end
      if (in_valid && in_ready)
        sb_q.push_back(model(in_sign, in_mantissa, in_exponent, in_guard, in_nan,
                             in_inf, in_zero, in_mode, in_tag));
    end
  end

  task automatic send(input logic s, input logic [23:0] mant, input logic [7:0] ex,
                      input logic [2:0] g, input logic nan, input logic inf, input logic zero,
                      input logic [2:0] mode, input logic [TW-1:0] tag);
    int k = 0;
    in_sign = s; in_mantissa = mant; in_exponent = ex; in_guard = g;
    in_nan = nan; in_inf = inf; in_zero = zero; in_mode = mode; in_tag = tag;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      k++;
    end while (!in_ready && k < 50);
    if (!in_ready) check("send_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [31:0] res, input logic [4:0] flg,
                            input logic [TW-1:0] tg);
    int lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 10);
    check({name, "_lat"}, 32'(lat), 32'd2);
    check({name, "_res"}, out_result, res);
    check({name, "_flags"}, 32'(out_flags), 32'(flg));
    check({name, "_tag"}, 32'(out_tag), 32'(tg));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((sb_q.size() != 0 || out_valid) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("drain", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic rand_drive();
    int unsigned r;
    r = $urandom % 8;
    case (r)
      0:       in_exponent = 8'h00;
      1:       in_exponent = 8'hFE;
      2:       in_exponent = 8'hFD;
      3:       in_exponent = 8'h01;
      default: in_exponent = 8'($urandom_range(1, 254));
    endcase
    r = $urandom % 4;
    case (r)
      0:       in_mantissa = 24'hFFFFFF;
      1:       in_mantissa = 24'h800000;
      default: in_mantissa = 24'($urandom);
    endcase
    in_mantissa[23] = (in_exponent != 8'h00);
    in_sign  = 1'($urandom);
    in_guard = 3'($urandom);
    in_mode  = 3'($urandom);
    in_nan   = ($urandom % 16) == 0;
    in_inf   = ($urandom % 16) == 0;
    in_zero  = ($urandom % 16) == 0;
    in_tag   = TW'($urandom);
    in_valid = ($urandom % 4) != 0;
    out_ready = ($urandom % 4) != 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_sign = 1'b0; in_mantissa = '0; in_exponent = '0; in_guard = '0;
    in_nan = 1'b0; in_inf = 1'b0; in_zero = 1'b0; in_mode = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_flags", 32'(out_flags), 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    send(0, 24'h800000, 8'h7F, 3'b000, 0, 0, 0, 3'd0, 4'd5);
    expect_out("basic", 32'h3F800000, 5'b00000, 4'd5);
    send(0, 24'h800001, 8'h7F, 3'b100, 0, 0, 0, 3'd0, 4'd1);
    expect_out("rne_tie_odd", 32'h3F800002, 5'b00001, 4'd1);
    send(0, 24'h800000, 8'h7F, 3'b100, 0, 0, 0, 3'd0, 4'd2);
    expect_out("rne_tie_even", 32'h3F800000, 5'b00001, 4'd2);
    send(0, 24'h800000, 8'h7F, 3'b100, 0, 0, 0, 3'd4, 4'd3);
    expect_out("rmm_tie", 32'h3F800001, 5'b00001, 4'd3);
    send(0, 24'hFFFFFF, 8'h7F, 3'b110, 0, 0, 0, 3'd0, 4'd4);
    expect_out("carry_out", 32'h40000000, 5'b00001, 4'd4);
    send(0, 24'hFFFFFF, 8'hFE, 3'b110, 0, 0, 0, 3'd0, 4'd6);
    expect_out("ovf_rne", 32'h7F800000, 5'b00101, 4'd6);
    send(0, 24'hFFFFFF, 8'hFE, 3'b110, 0, 0, 0, 3'd1, 4'd7);
    expect_out("ovf_rtz", 32'h7F7FFFFF, 5'b00001, 4'd7);
    send(1, 24'hFFFFFF, 8'hFE, 3'b110, 0, 0, 0, 3'd3, 4'd8);
    expect_out("neg_rup", 32'hFF7FFFFF, 5'b00001, 4'd8);
    send(1, 24'hFFFFFF, 8'hFE, 3'b110, 0, 0, 0, 3'd2, 4'd9);
    expect_out("ovf_rdn_neg", 32'hFF800000, 5'b00101, 4'd9);
    send(0, 24'h123456, 8'h10, 3'b101, 1, 1, 0, 3'd0, 4'd10);
    expect_out("nan_inf", 32'h7FC00000, 5'b00000, 4'd10);
    send(1, 24'h000000, 8'h00, 3'b000, 0, 0, 1, 3'd0, 4'd11);
    expect_out("neg_zero", 32'h80000000, 5'b00000, 4'd11);
    send(0, 24'h7FFFFF, 8'h00, 3'b100, 0, 0, 0, 3'd0, 4'd12);
    expect_out("sub_to_norm", 32'h00800000, 5'b00001, 4'd12);
    send(0, 24'h000001, 8'h00, 3'b010, 0, 0, 0, 3'd3, 4'd13);
`ifdef FPU_ROUND_FTZ_EN
    expect_out("sub_rup", 32'h00000000, 5'b00011, 4'd13);
`else
    expect_out("sub_rup", 32'h00000002, 5'b00011, 4'd13);
`endif

    // Backpressure: four back-to-back ops while the sink stalls.
    out_ready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 4; i++)
          send(1'(i), 24'h800000 | 24'(i * 3), 8'(8'h40 + i), 3'(i + 3), 0, 0, 0, 3'(i), TW'(i));
      end
      begin
        repeat (3) @(negedge clk);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset with both stages full discards everything in flight.
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(0, 24'h900000, 8'h50, 3'b001, 0, 0, 0, 3'd0, 4'd14);
    send(1, 24'hA00000, 8'h51, 3'b011, 0, 0, 0, 3'd0, 4'd15);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("mid_rst_no_stale", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    for (int c = 0; c < 3000; c++) begin
      rand_drive();
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
